uart_tx_seq: RTL and testbench

Buffered transmit front-end that sits between the core (or a bring-up harness) and `uart_tx`. It accepts bytes through a parametrised FIFO and serialises them onto the `uart_tx` `tdata`/`tx_start`/`tx_busy` handshake one at a time. It holds off all transmission for a programmable number of cycles after reset, and reports FIFO overflow. It replaces hand-timed single-byte `tx_start` pulses with a reusable, multi-byte, back-pressure-aware sender.

---
 rtl/uart_tx_seq.sv | 135 +++++++++++++
 tb/tb_uart_tx_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_seq.sv
// Buffered byte sender for uart_tx: FIFO in front, one tx_start per byte,
// start-up hold-off after reset and a sticky overflow flag.
module uart_tx_seq #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int HOLDOFF      = 20,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [WIDTH-1:0]           tdata,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tx_start_q, tx_start_d;
  logic             overflow_q, overflow_d;
  logic             accept;
  logic             pop;
  logic             holdoff_done;

  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tdata    = tdata_q;
  assign tx_start = tx_start_q;
  assign idle     = (state_q == S_IDLE) && (count_q == '0) && holdoff_done;

  always_comb begin
    holdoff_done = (hcnt_q == HW'(HOLDOFF));
    accept       = wr_en && !full;
    pop          = 1'b0;
    state_d      = state_q;
    tmo_d        = tmo_q;
    tdata_d      = tdata_q;
    tx_start_d   = 1'b0;
    hcnt_d       = holdoff_done ? hcnt_q : hcnt_q + HW'(1);
    // Acceptance looks only at full before this edge, so a same-edge pop cannot rescue a write.
    overflow_d   = overflow_q | (wr_en & full);

    case (state_q)
      S_IDLE: begin
        // Never start into a transmitter that still reports busy.
        if (holdoff_done && (count_q != '0) && !tx_busy) begin
          state_d    = S_START;
          pop        = 1'b1;
          tdata_d    = mem[rd_ptr_q];
          tx_start_d = 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
        tmo_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(accept);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hcnt_q     <= '0;
      tmo_q      <= '0;
      tdata_q    <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hcnt_q     <= hcnt_d;
      tmo_q      <= tmo_d;
      tdata_q    <= tdata_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_seq.sv
// Self-checking bench for uart_tx_seq: a uart_tx busy model, a byte-order
// scoreboard and an occupancy model that predicts accepted/dropped writes.
module tb_uart_tx_seq;
  localparam int WIDTH        = 8;
  localparam int DEPTH        = 16;
  localparam int HOLDOFF      = 20;
  localparam int BUSY_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             full;
  logic [4:0]       count;
  logic             overflow;
  logic [WIDTH-1:0] tdata;
  logic             tx_start;
  logic             tx_busy;
  logic             idle;

  int compared = 0;
  int mismatched = 0;
  int cyc;
  int rel_cyc = 0;
  int busy_mode = 0;   // 0: busy for busy_len cycles per start, 1: tied 0, 2: held 1
  int busy_len = 40;
  int busy_cnt;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] sent_q[$];
  int               start_q[$];
  int               viol_busy = 0;
  int               viol_tdata = 0;
  logic             prev_busy = 1'b0;
  logic [WIDTH-1:0] prev_tdata = '0;
  logic             model_ovf = 1'b0;

  uart_tx_seq #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .count(count), .overflow(overflow), .tdata(tdata), .tx_start(tx_start),
    .tx_busy(tx_busy), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = (busy_mode == 2) || (busy_mode == 0 && busy_cnt != 0);

  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start && busy_mode == 0) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        sent_q.push_back(tdata);
        start_q.push_back(cyc - rel_cyc);
        if (tx_busy) viol_busy++;
      end
      if (tx_busy && prev_busy && tdata !== prev_tdata) viol_tdata++;
    end
    prev_busy  = tx_busy;
    prev_tdata = tdata;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete(); sent_q.delete(); start_q.delete();
    model_ovf = 1'b0;
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  // Model: a write is dropped iff accepted-minus-started already equals DEPTH.
  task automatic wr(input logic [WIDTH-1:0] b);
    @(negedge clk); #1;
    if (exp_q.size() - sent_q.size() >= DEPTH) model_ovf = 1'b1;
    else exp_q.push_back(b);
    wr_en = 1'b1;
    wr_data = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while (!(sent_q.size() == exp_q.size() && idle === 1'b1) && k < maxc) begin
      @(negedge clk); #1;
      k++;
    end
    compared++;
    if (k >= maxc) begin
      mismatched++;
      $display("FAIL drain: sent %0d idle %b after %0d cycles, want %0d sent and idle", sent_q.size(), idle, k, exp_q.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    compared++; if (count !== 5'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", count); end
    compared++; if (full !== 1'b0) begin mismatched++; $display("FAIL reset_full: got %b want 0", full); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    compared++; if (tdata !== 8'h00) begin mismatched++; $display("FAIL reset_tdata: got %h want 00", tdata); end
    compared++; if (tx_start !== 1'b0) begin mismatched++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    compared++; if (idle !== 1'b0) begin mismatched++; $display("FAIL reset_idle: got %b want 0", idle); end
    $display("reset: count=%0d full=%b overflow=%b idle=%b", count, full, overflow, idle);
  endtask

  task automatic test_holdoff();
    int k = 0;
    logic idle_seen = 1'b0;
    busy_mode = 0; busy_len = 40;
    apply_reset();
    wr(8'h55);
    while (sent_q.size() == 0 && k < 100) begin
      @(negedge clk); #1;
      if (sent_q.size() == 0 && idle !== 1'b0) idle_seen = 1'b1;
      k++;
    end
    compared++;
    if (sent_q.size() == 0) begin
      mismatched++; $display("FAIL holdoff_start: no tx_start in 100 cycles, want one");
    end else begin
      compared++; if (start_q[0] != HOLDOFF + 1) begin mismatched++; $display("FAIL holdoff_cycle: got %0d want %0d", start_q[0], HOLDOFF + 1); end
      compared++; if (sent_q[0] !== 8'h55) begin mismatched++; $display("FAIL holdoff_tdata: got %h want 55", sent_q[0]); end
      $display("holdoff: first tx_start at cycle %0d tdata=%h", start_q[0], sent_q[0]);
    end
    compared++; if (idle_seen !== 1'b0) begin mismatched++; $display("FAIL holdoff_idle: idle rose %b before first start, want 0", idle_seen); end
    drain(200);
  endtask

  task automatic test_burst();
    int base = sent_q.size();
    busy_mode = 0; busy_len = 40;
    wr(8'h01); wr(8'h02); wr(8'h03);
    drain(600);
    compared++;
    if (sent_q.size() != base + 3) begin
      mismatched++; $display("FAIL burst_len: got %0d bytes want 3", sent_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        compared++; if (sent_q[base+i] !== 8'(i + 1)) begin mismatched++; $display("FAIL burst_byte%0d: got %h want %h", i, sent_q[base+i], 8'(i + 1)); end
        $display("burst: byte %0d = %h at cycle %0d", i, sent_q[base+i], start_q[base+i]);
      end
      for (int i = 1; i < 3; i++) begin
        compared++; if (start_q[base+i] - start_q[base+i-1] < 40) begin mismatched++; $display("FAIL burst_gap%0d: got %0d want >=40", i, start_q[base+i] - start_q[base+i-1]); end
      end
    end
    compared++; if (count !== 5'd0) begin mismatched++; $display("FAIL burst_count: got %0d want 0", count); end
    compared++; if (idle !== 1'b1) begin mismatched++; $display("FAIL burst_idle: got %b want 1", idle); end
  endtask

  task automatic test_timeout();
    int base = sent_q.size();
    busy_mode = 1;
    wr(8'hA5); wr(8'h3C);
    drain(200);
    compared++;
    if (sent_q.size() != base + 2) begin
      mismatched++; $display("FAIL timeout_len: got %0d bytes want 2", sent_q.size() - base);
    end else begin
      compared++; if (sent_q[base] !== 8'hA5) begin mismatched++; $display("FAIL timeout_byte0: got %h want a5", sent_q[base]); end
      compared++; if (sent_q[base+1] !== 8'h3C) begin mismatched++; $display("FAIL timeout_byte1: got %h want 3c", sent_q[base+1]); end
      compared++; if (start_q[base+1] - start_q[base] != BUSY_TIMEOUT + 2) begin mismatched++; $display("FAIL timeout_gap: got %0d want %0d", start_q[base+1] - start_q[base], BUSY_TIMEOUT + 2); end
      $display("timeout: bytes %h %h gap %0d", sent_q[base], sent_q[base+1], start_q[base+1] - start_q[base]);
    end
    compared++; if (idle !== 1'b1) begin mismatched++; $display("FAIL timeout_idle: got %b want 1", idle); end
  endtask

  task automatic test_wrap();
    int base = sent_q.size();
    busy_mode = 0;
    for (int n = 0; n < 40; n++) begin
      busy_len = $urandom_range(2, 8);
      wr(8'($urandom));
      drain(100);
    end
    compared++;
    if (sent_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL wrap_len: got %0d bytes want %0d", sent_q.size(), exp_q.size());
    end else begin
      for (int i = base; i < exp_q.size(); i++) begin
        compared++; if (sent_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL wrap_byte%0d: got %h want %h", i - base, sent_q[i], exp_q[i]); end
      end
    end
    $display("wrap: %0d bytes sent, last %h", sent_q.size() - base, tdata);
  endtask

  task automatic test_full();
    int base = sent_q.size();
    busy_mode = 2;
    repeat (18) wr(8'($urandom));
    @(negedge clk); #1;
    compared++; if (full !== 1'b1) begin mismatched++; $display("FAIL full_flag: got %b want 1", full); end
    compared++; if (int'(count) != exp_q.size() - sent_q.size()) begin mismatched++; $display("FAIL full_count: got %0d want %0d", count, exp_q.size() - sent_q.size()); end
    compared++; if (overflow !== model_ovf) begin mismatched++; $display("FAIL full_overflow: got %b want %b", overflow, model_ovf); end
    $display("full: count=%0d full=%b overflow=%b accepted=%0d", count, full, overflow, exp_q.size() - base);
    busy_mode = 0; busy_len = 3;
    drain(800);
    compared++;
    if (sent_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL full_len: got %0d bytes want %0d", sent_q.size(), exp_q.size());
    end else begin
      for (int i = base; i < exp_q.size(); i++) begin
        compared++; if (sent_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL full_byte%0d: got %h want %h", i - base, sent_q[i], exp_q[i]); end
      end
    end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL full_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    int base = sent_q.size();
    int k = 0;
    busy_mode = 0; busy_len = 40;
    repeat (4) wr(8'($urandom));
    while (!(tx_busy === 1'b1 && sent_q.size() > base) && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    compared++; if (int'(count) != exp_q.size() - sent_q.size()) begin mismatched++; $display("FAIL mid_queued: got %0d want %0d", count, exp_q.size() - sent_q.size()); end
    rst = 1'b1;
    #1;
    compared++; if (count !== 5'd0) begin mismatched++; $display("FAIL mid_count: got %0d want 0", count); end
    compared++; if (tx_start !== 1'b0) begin mismatched++; $display("FAIL mid_tx_start: got %b want 0", tx_start); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL mid_overflow: got %b want 0", overflow); end
    $display("reset_mid: count=%0d tx_start=%b overflow=%b", count, tx_start, overflow);
    repeat (2) @(negedge clk);
    exp_q.delete(); sent_q.delete(); start_q.delete();
    model_ovf = 1'b0;
    rst = 1'b0;
    rel_cyc = cyc;
    repeat (HOLDOFF + 10) @(negedge clk);
    #1;
    compared++; if (sent_q.size() != 0) begin mismatched++; $display("FAIL mid_silent: got %0d starts want 0", sent_q.size()); end
    compared++; if (idle !== 1'b1) begin mismatched++; $display("FAIL mid_idle: got %b want 1", idle); end
    busy_len = 5;
    wr(8'h77);
    drain(100);
    compared++;
    if (sent_q.size() != 1) begin
      mismatched++; $display("FAIL mid_resume_len: got %0d bytes want 1", sent_q.size());
    end else begin
      compared++; if (sent_q[0] !== 8'h77) begin mismatched++; $display("FAIL mid_resume_byte: got %h want 77", sent_q[0]); end
      $display("reset_mid: resumed with %h at cycle %0d", sent_q[0], start_q[0]);
    end
  endtask

  task automatic test_protocol();
    compared++; if (viol_busy != 0) begin mismatched++; $display("FAIL start_while_busy: got %0d want 0", viol_busy); end
    compared++; if (viol_tdata != 0) begin mismatched++; $display("FAIL tdata_change_while_busy: got %0d want 0", viol_tdata); end
  endtask

  initial begin
    test_reset();
    test_holdoff();
    test_burst();
    test_timeout();
    test_wrap();
    test_full();
    test_reset_mid();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
